// File: rtl/adc_spi_multi_if.sv
// Bus bundle for the multi-channel SPI ADC reader: control requests,
// per-channel serial data, shared SPI strobes and the packed result.
interface adc_spi_multi_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 12
);
  logic                     read;
  logic                     continuous;
  logic                     recalibrate;
  logic [NUM_CH-1:0]        sdo;
  logic                     cs;
  logic                     sclk;
  logic [NUM_CH*DATA_W-1:0] value;
  logic                     valid;
  logic                     busy;

  // Controller / ADC side: issues requests, supplies serial data.
  modport master (
    output read, continuous, recalibrate, sdo,
    input  cs, sclk, value, valid, busy
  );

  // Reader side.
  modport slave (
    input  read, continuous, recalibrate, sdo,
    output cs, sclk, value, valid, busy
  );
endinterface

// File: rtl/adc_spi_multi.sv
// Multi-channel SPI ADC reader: one shared cs/sclk, one sdo per ADC.
// Every frame captures all channels at once; dummy (recalibration) frames
// run the identical waveform but leave value untouched and never strobe valid.
module adc_spi_multi #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CYC  = 4
) (
  input  logic             clk,
  input  logic             reset,
  adc_spi_multi_if.slave   bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int QCW   = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t                   state, state_nxt;
  logic [DIV_W-1:0]         div_cnt, div_nxt;
  logic                     phase, phase_nxt;     // 0: sclk low half, 1: sclk high half
  logic [BIT_W-1:0]         bit_cnt, bit_nxt;
  logic [QCW-1:0]           q_cnt, q_nxt;
  logic                     dummy, dummy_nxt;     // current frame is a recalibration frame
  logic                     recal_pending, recal_nxt;
  logic                     sample_en;
  logic                     load_en;
  logic                     div_end;
  logic                     q_end;
  logic [BIT_W-1:0]         cap_idx;
  logic [DATA_W-1:0]        sr [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] value_q;
  logic                     valid_q;

  assign div_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign q_end   = (q_cnt == QCW'(QUIET_CYC - 1));
  // Bits before the lead window wrap to large values, so one compare
  // selects exactly the DATA_W data bits.
  assign cap_idx = bit_cnt - BIT_W'(LEAD_BITS);

  // State and sequencing counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      phase         <= 1'b0;
      bit_cnt       <= '0;
      q_cnt         <= '0;
      dummy         <= 1'b0;
      recal_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_cnt       <= div_nxt;
      phase         <= phase_nxt;
      bit_cnt       <= bit_nxt;
      q_cnt         <= q_nxt;
      dummy         <= dummy_nxt;
      recal_pending <= recal_nxt;
    end
  end

  // Frame sequencing: next state, counters and datapath strobes.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    q_nxt     = q_cnt;
    dummy_nxt = dummy;
    recal_nxt = recal_pending | bus.recalibrate;
    sample_en = 1'b0;
    load_en   = 1'b0;
    unique case (state)
      IDLE: begin
        // Recalibration wins; a simultaneous read is dropped, not queued.
        if (recal_pending || bus.recalibrate) begin
          state_nxt = SETUP;
          dummy_nxt = 1'b1;
          recal_nxt = 1'b0;
          div_nxt   = '0;
        end else if (bus.read || bus.continuous) begin
          state_nxt = SETUP;
          dummy_nxt = 1'b0;
          div_nxt   = '0;
        end
      end
      SETUP: begin
        if (div_end) begin
          state_nxt = SHIFT;
          div_nxt   = '0;
          phase_nxt = 1'b0;
          bit_nxt   = '0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (!div_end) begin
          div_nxt = div_cnt + 1'b1;
        end else begin
          div_nxt = '0;
          if (!phase) begin
            phase_nxt = 1'b1;
            sample_en = (cap_idx < BIT_W'(DATA_W));
          end else begin
            phase_nxt = 1'b0;
            if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
              state_nxt = QUIET;
              q_nxt     = '0;
              load_en   = !dummy;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
        end
      end
      QUIET: begin
        if (q_end) begin
          state_nxt = IDLE;
        end else begin
          q_nxt = q_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-channel shift registers and the result register, kept separate so
  // value only ever changes as a whole at end of frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      valid_q <= 1'b0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        sr[ch] <= '0;
      end
    end else begin
      valid_q <= load_en;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (sample_en) begin
          sr[ch] <= DATA_W'({sr[ch], bus.sdo[ch]});
        end
        if (load_en) begin
          value_q[ch*DATA_W +: DATA_W] <= sr[ch];
        end
      end
    end
  end

  assign bus.cs    = !((state == SETUP) || (state == SHIFT));
  assign bus.sclk  = !((state == SHIFT) && !phase);
  assign bus.busy  = (state != IDLE);
  assign bus.value = value_q;
  assign bus.valid = valid_q;

endmodule
